// File: rtl/bch_pkg.sv
// Shared constants for the GF(2^13), t=8 BCH encoder: field, code sizes, FSM states, generator polynomial.
package bch_pkg;

    localparam int GF_M     = 13;
    localparam int GF_N     = 8191;
    localparam int T_CORR   = 8;
    localparam int PAR_BITS = 104;

    // Low-order taps of the primitive polynomial x^13 + x^4 + x^3 + x + 1.
    localparam logic [GF_M-1:0] GF_PRIM_LOW = 13'h001B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MSG    = 2'd1,
        ST_PARITY = 2'd2
    } bch_state_e;

    function automatic logic [GF_M-1:0] gf_mul(input logic [GF_M-1:0] a, input logic [GF_M-1:0] b);
        logic [GF_M-1:0] acc;
        logic [GF_M-1:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < GF_M; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[GF_M-1] ? ({x[GF_M-2:0], 1'b0} ^ GF_PRIM_LOW) : {x[GF_M-2:0], 1'b0};
        end
        return acc;
    endfunction

    // Minimal polynomial of root: product of (x + root^(2^j)) over its 13 conjugates.
    function automatic logic [GF_M:0] min_poly(input logic [GF_M-1:0] root);
        logic [GF_M:0][GF_M-1:0] mp;
        logic [GF_M-1:0]         beta;
        logic [GF_M:0]           res;
        mp    = '0;
        mp[0] = 13'd1;
        beta  = root;
        for (int j = 0; j < GF_M; j++) begin
            for (int k = GF_M; k > 0; k--) begin
                mp[k] = mp[k-1] ^ gf_mul(mp[k], beta);
            end
            mp[0] = gf_mul(mp[0], beta);
            beta  = gf_mul(beta, beta);
        end
        for (int k = 0; k <= GF_M; k++) begin
            res[k] = mp[k][0];
        end
        return res;
    endfunction

    // g(x) = product of the minimal polynomials of alpha^1, alpha^3, ..., alpha^15.
    function automatic logic [PAR_BITS-1:0] gen_poly();
        logic [PAR_BITS:0] g;
        logic [PAR_BITS:0] acc;
        logic [GF_M:0]     m;
        logic [GF_M-1:0]   root;
        g    = '0;
        g[0] = 1'b1;
        root = 13'd2;
        for (int i = 1; i < 2 * T_CORR; i += 2) begin
            m   = min_poly(root);
            acc = '0;
            for (int k = 0; k <= GF_M; k++) begin
                if (m[k]) acc = acc ^ (g << k);
            end
            g    = acc;
            root = gf_mul(gf_mul(root, 13'd2), 13'd2);
        end
        return g[PAR_BITS-1:0];
    endfunction

    // x^104 term is implicit.
    localparam logic [PAR_BITS-1:0] BCH_GEN_POLY = gen_poly();

endpackage

// File: rtl/bch_serial_encoder_lfsr.sv
// bch_gen_lfsr: 104-bit Galois-form divider by g(x); parity leaves through the MSB tap.
module bch_gen_lfsr
    import bch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic shift_en,
    input  logic fb_en,
    input  logic din,
    output logic par_tap
);

    logic [PAR_BITS-1:0] lfsr_q;
    logic [PAR_BITS-1:0] lfsr_d;
    logic                fb;

    always_comb begin
        fb     = din ^ lfsr_q[PAR_BITS-1];
        lfsr_d = lfsr_q;
        if (clr) begin
            lfsr_d = '0;
        end else if (shift_en) begin
            // Without feedback the register just drains its remainder MSB first.
            lfsr_d = {lfsr_q[PAR_BITS-2:0], 1'b0} ^ ({PAR_BITS{fb & fb_en}} & BCH_GEN_POLY);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign par_tap = lfsr_q[PAR_BITS-1];

endmodule

// File: rtl/bch_serial_encoder.sv
// bch_serial_encoder: bit-serial systematic BCH encoder, K_MSG message bits followed by 104 parity bits.
// Build option: define BCH_ENC_PARITY_INV_EN to emit parity bits inverted (message bits are unaffected).
module bch_serial_encoder
    import bch_pkg::*;
#(
    parameter int K_MSG = 4096,
    parameter int CNT_W = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic din,
    input  logic din_valid,
    output logic din_ready,
    output logic dout,
    output logic dout_valid,
    output logic dout_parity,
    output logic dout_last,
    output logic busy
);

    if (K_MSG < 1 || K_MSG > GF_N - PAR_BITS || (2 ** CNT_W) <= K_MSG || (2 ** CNT_W) <= PAR_BITS)
    begin : g_bad_params
        $error("bch_serial_encoder: K_MSG/CNT_W out of range");
    end

    localparam logic [CNT_W-1:0] CNT_MSG_LAST = CNT_W'(K_MSG - 1);
    localparam logic [CNT_W-1:0] CNT_PAR_LAST = CNT_W'(PAR_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_PAR_END  = CNT_W'(PAR_BITS);

    bch_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_parity_q, dout_parity_d;
    logic             dout_last_q, dout_last_d;

    logic lfsr_clr;
    logic lfsr_shift;
    logic lfsr_fb;
    logic par_tap;
    logic par_bit;
    logic accept;

    bch_gen_lfsr u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .clr      (lfsr_clr),
        .shift_en (lfsr_shift),
        .fb_en    (lfsr_fb),
        .din      (din),
        .par_tap  (par_tap)
    );

`ifdef BCH_ENC_PARITY_INV_EN
    assign par_bit = ~par_tap;
`else
    assign par_bit = par_tap;
`endif

    assign din_ready = (state_q == ST_MSG);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = din_valid & din_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dout_d        = 1'b0;
        dout_valid_d  = 1'b0;
        dout_parity_d = 1'b0;
        dout_last_d   = 1'b0;
        lfsr_clr      = 1'b0;
        lfsr_shift    = 1'b0;
        lfsr_fb       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_MSG;
                    cnt_d    = '0;
                    lfsr_clr = 1'b1;
                end
            end
            ST_MSG: begin
                if (accept) begin
                    lfsr_shift   = 1'b1;
                    lfsr_fb      = 1'b1;
                    dout_d       = din;
                    dout_valid_d = 1'b1;
                    if (cnt_q == CNT_MSG_LAST) begin
                        state_d = ST_PARITY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                // cnt reaches 104 only after the last parity bit is on dout; that cycle retires the frame.
                if (cnt_q == CNT_PAR_END) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    lfsr_shift    = 1'b1;
                    dout_d        = par_bit;
                    dout_valid_d  = 1'b1;
                    dout_parity_d = 1'b1;
                    dout_last_d   = (cnt_q == CNT_PAR_LAST);
                    cnt_d         = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            dout_q        <= 1'b0;
            dout_valid_q  <= 1'b0;
            dout_parity_q <= 1'b0;
            dout_last_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            dout_parity_q <= dout_parity_d;
            dout_last_q   <= dout_last_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign dout_parity = dout_parity_q;
    assign dout_last   = dout_last_q;

endmodule

// File: tb/tb_bch_serial_encoder.sv
// Directed bench for bch_serial_encoder with K_MSG=16: framing, parity values, codeword syndromes, start/reset handling.
module tb_bch_serial_encoder;
    import bch_pkg::*;

    localparam int K   = 16;
    localparam int NCW = K + PAR_BITS;

`ifdef BCH_ENC_PARITY_INV_EN
    localparam logic [PAR_BITS-1:0] PAR_INV = '1;
`else
    localparam logic [PAR_BITS-1:0] PAR_INV = '0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic din;
    logic din_valid;
    logic din_ready;
    logic dout;
    logic dout_valid;
    logic dout_parity;
    logic dout_last;
    logic busy;

    always #5 clk = ~clk;

    bch_serial_encoder #(.K_MSG(K), .CNT_W(13)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_parity (dout_parity),
        .dout_last   (dout_last),
        .busy        (busy)
    );

    int n_chk = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int ncap = 0;
    int last_idx = -1;
    logic cap_bit [128];
    logic cap_par [128];
    int   cap_cyc [128];
    logic       busy_at_last;
    logic [1:0] after_last;
    logic [NCW-1:0] golden_cw;
    logic [NCW-1:0] last_cw;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
        if (dout_valid === 1'b1) begin
            if (ncap < 128) begin
                cap_bit[ncap] = dout;
                cap_par[ncap] = dout_parity;
                cap_cyc[ncap] = cyc_n;
                if (dout_last === 1'b1) last_idx = ncap;
            end
            ncap++;
        end
    endtask

    function automatic logic [12:0] tb_gmul(input logic [12:0] a, input logic [12:0] b);
        logic [25:0] p;
        p = '0;
        for (int i = 0; i < 13; i++) if (b[i]) p = p ^ (26'(a) << i);
        for (int i = 25; i >= 13; i--) if (p[i]) p = p ^ (26'h201B << (i - 13));
        return p[12:0];
    endfunction

    // Number of nonzero syndromes c(alpha^j), j=1..16; a valid codeword gives 0.
    function automatic int count_synd(input logic [NCW-1:0] cw);
        int n;
        logic [12:0] a;
        logic [12:0] s;
        n = 0;
        for (int j = 1; j <= 16; j++) begin
            a = 13'd1;
            for (int r = 0; r < j; r++) a = tb_gmul(a, 13'd2);
            s = '0;
            for (int i = NCW - 1; i >= 0; i--) s = tb_gmul(s, a) ^ {12'd0, cw[i]};
            if (s != 13'd0) n++;
        end
        return n;
    endfunction

    function automatic logic [PAR_BITS-1:0] ref_parity(input logic [K-1:0] m);
        logic [NCW-1:0] r;
        r = {m, {PAR_BITS{1'b0}}};
        for (int i = NCW - 1; i >= PAR_BITS; i--) begin
            if (r[i]) r[i -: (PAR_BITS + 1)] = r[i -: (PAR_BITS + 1)] ^ {1'b1, BCH_GEN_POLY};
        end
        return r[PAR_BITS-1:0];
    endfunction

    task automatic run_frame(input logic [K-1:0] m, input bit gaps, input bit poke);
        int sent;
        bit done;
        sent = 0;
        done = 1'b0;
        ncap = 0;
        last_idx = -1;
        busy_at_last = 1'b0;
        after_last = 2'b11;
        for (int i = 0; i < 128; i++) begin
            cap_bit[i] = 1'b0;
            cap_par[i] = 1'b0;
            cap_cyc[i] = 0;
        end
        start = 1'b1;
        din_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            din_valid = 1'b0;
            if (din_ready && sent < K && !(gaps && $urandom_range(0, 1) == 0)) begin
                din_valid = 1'b1;
                din = m[K-1-sent];
                sent++;
            end
            start = poke && busy;
            tick();
            if (dout_valid === 1'b1 && dout_last === 1'b1) begin
                start = 1'b0;
                din_valid = 1'b0;
                busy_at_last = busy;
                tick();
                after_last = {busy, dout_valid};
                done = 1'b1;
            end
        end
        start = 1'b0;
        din_valid = 1'b0;
        if (!done) chk("timeout", 128'(0), 128'(1));
    endtask

    task automatic check_frame(input string tag, input logic [K-1:0] m, input logic [PAR_BITS-1:0] exp_par);
        logic [K-1:0]        got_msg;
        logic [PAR_BITS-1:0] got_par;
        logic [NCW-1:0]      got_flags;
        for (int i = 0; i < K; i++) got_msg[K-1-i] = cap_bit[i];
        for (int i = 0; i < PAR_BITS; i++) got_par[PAR_BITS-1-i] = cap_bit[K+i];
        for (int i = 0; i < NCW; i++) got_flags[NCW-1-i] = cap_par[i];
        last_cw = {got_msg, got_par ^ PAR_INV};
        chk({tag, ".count"}, 128'(ncap), 128'(NCW));
        chk({tag, ".msg"}, 128'(got_msg), 128'(m));
        chk({tag, ".par"}, 128'(got_par), 128'(exp_par ^ PAR_INV));
        chk({tag, ".flags"}, 128'(got_flags), 128'({{K{1'b0}}, {PAR_BITS{1'b1}}}));
        chk({tag, ".last"}, 128'(last_idx), 128'(NCW - 1));
        chk({tag, ".gapfree"}, 128'(cap_cyc[NCW-1] - cap_cyc[K-1]), 128'(PAR_BITS));
        chk({tag, ".busy_last"}, 128'(busy_at_last), 128'(1));
        chk({tag, ".after_last"}, 128'(after_last), 128'(0));
        chk({tag, ".synd"}, 128'(count_synd(last_cw)), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        din = 1'b0;
        din_valid = 1'b0;
        repeat (3) tick();
        chk("reset.outs", 128'({dout, dout_valid, dout_parity, dout_last, busy, din_ready}), 128'(0));
        reset = 1'b1;
        tick();
        chk("idle.outs", 128'({dout_valid, busy, din_ready}), 128'(0));

        // T1: all-zero message gives all-zero parity
        run_frame(16'h0000, 1'b0, 1'b0);
        check_frame("t1", 16'h0000, {PAR_BITS{1'b0}});

        // T2: m(x)=1 gives x^104 mod g(x) = g(x) without its leading term
        run_frame(16'h0001, 1'b0, 1'b0);
        check_frame("t2", 16'h0001, BCH_GEN_POLY);

        // T3: mixed message with input gaps
        run_frame(16'hB5C3, 1'b1, 1'b0);
        check_frame("t3", 16'hB5C3, ref_parity(16'hB5C3));
        golden_cw = last_cw;

        // T4: start held during MSG and PARITY is ignored
        run_frame(16'hB5C3, 1'b1, 1'b1);
        check_frame("t4", 16'hB5C3, ref_parity(16'hB5C3));
        chk("t4.golden", 128'(last_cw), 128'(golden_cw));

        // T5: reset at message bit 7 aborts the frame
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            din_valid = 1'b1;
            din = i[0];
            tick();
        end
        din = 1'b1;
        reset = 1'b0;
        tick();
        chk("t5.reset", 128'({dout, dout_valid, dout_parity, dout_last, busy, din_ready}), 128'(0));
        reset = 1'b1;
        din_valid = 1'b0;
        tick();
        tick();
        chk("t5.idle", 128'({dout_valid, busy, din_ready}), 128'(0));
        run_frame(16'h3E91, 1'b0, 1'b0);
        check_frame("t5", 16'h3E91, ref_parity(16'h3E91));

        // Back-to-back: the start right after the previous frame's idle cycle
        run_frame(16'hFFFF, 1'b1, 1'b0);
        check_frame("b2b", 16'hFFFF, ref_parity(16'hFFFF));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
